// File: rtl/pre_if_stage_pkg.sv
// Shared constants, bus payload layouts and redirect priority helpers for the preIF stage.
package pre_if_stage_pkg;

   localparam int unsigned BR_BUS_LEN      = 34;
   localparam int unsigned PREIF_TO_IF_LEN = 112;
   localparam int unsigned IO_CNT_W        = 4;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
   localparam logic [14:0] ECODE_ADEF       = 15'h0008;
   localparam logic [8:0]  ESUBCODE_ADEF    = 9'h000;

   // Ordered so that a numerically larger level wins.
   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_BR   = 2'd1,
      REDIR_ERTN = 2'd2,
      REDIR_EX   = 2'd3
   } redir_lvl_e;

   typedef struct packed {
      logic [31:0] target;
      logic        taken;
      logic        taken_cancel;
   } br_bus_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] nextpc;
      logic        ex;
      logic [14:0] ex_code;
      logic [31:0] ex_vaddr;
   } preif_to_if_bus_t;

   function automatic redir_lvl_e redir_pulse_lvl(input logic wb_ex,
                                                  input logic ertn_flush,
                                                  input logic br_taken);
      if (wb_ex) begin
         return REDIR_EX;
      end else if (ertn_flush) begin
         return REDIR_ERTN;
      end else if (br_taken) begin
         return REDIR_BR;
      end
      return REDIR_NONE;
   endfunction

   // ADEF code as {esubcode, ecode} in the 15-bit ex_code field.
   function automatic logic [14:0] adef_ex_code();
      return ECODE_ADEF | {ESUBCODE_ADEF, 6'h00};
   endfunction

endpackage

// File: rtl/pre_if_redirect_buf.sv
// Holds a redirect target that arrived while no handoff could take it, until the next handoff.
module pre_if_redirect_buf
   import pre_if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  redir_lvl_e  pulse_lvl,
   input  logic [31:0] pulse_target,
   input  logic        handoff,
   output logic        pulse_win_c,
   output logic        held_valid,
   output logic [31:0] held_target
);

   redir_lvl_e  held_lvl_q, held_lvl_d;
   logic [31:0] held_target_q, held_target_d;

   // A pulse only displaces a held redirect of equal or lower priority.
   assign pulse_win_c = (pulse_lvl != REDIR_NONE) && (pulse_lvl >= held_lvl_q);

   always_comb begin
      held_lvl_d    = held_lvl_q;
      held_target_d = held_target_q;
      if (handoff) begin
         held_lvl_d    = REDIR_NONE;
         held_target_d = 32'h0;
      end else if (pulse_win_c) begin
         held_lvl_d    = pulse_lvl;
         held_target_d = pulse_target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held_lvl_q    <= REDIR_NONE;
         held_target_q <= 32'h0;
      end else begin
         held_lvl_q    <= held_lvl_d;
         held_target_q <= held_target_d;
      end
   end

   assign held_valid  = (held_lvl_q != REDIR_NONE);
   assign held_target = held_target_q;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-fetch stage: picks the next fetch PC, issues inst SRAM requests, tracks
// outstanding reads and hands the accepted PC (or an ADEF exception) to IF.
module pre_if_stage
   import pre_if_stage_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       reset,
   output logic                       inst_sram_req,
   output logic                       inst_sram_wr,
   output logic [1:0]                 inst_sram_size,
   output logic [3:0]                 inst_sram_wstrb,
   output logic [31:0]                inst_sram_wdata,
   output logic [31:0]                inst_sram_addr,
   input  logic                       inst_sram_addr_ok,
   input  logic                       inst_sram_data_ok,
   input  logic [BR_BUS_LEN-1:0]      BR_BUS,
   input  logic                       wb_ex,
   input  logic                       ertn_flush,
   input  logic [31:0]                ex_entry,
   input  logic [31:0]                era,
   input  logic [31:0]                if_pc,
   input  logic                       IF_allowin,
   output logic                       preIF_to_IF_valid,
   output logic [PREIF_TO_IF_LEN-1:0] preIF_to_IF_BUS,
   output logic [IO_CNT_W-1:0]        IO_cnt
);

   br_bus_t          br_bus;
   redir_lvl_e       pulse_lvl;
   logic [31:0]      pulse_target;
   logic             pulse_win_c;
   logic             held_valid;
   logic [31:0]      held_target;
   logic [31:0]      nextpc_c;
   logic             adef_c;
   logic             req_c;
   logic             handshake_c;
   logic             adef_issue_c;
   logic             valid_c;
   preif_to_if_bus_t bus_c;

   logic                started_q, started_d;
   logic                ex_stall_q, ex_stall_d;
   logic [IO_CNT_W-1:0] io_cnt_q, io_cnt_d;
   logic [31:0]         preif_pc_q, preif_pc_d;

   logic unused_br_cancel;

   assign br_bus           = br_bus_t'(BR_BUS);
   assign unused_br_cancel = br_bus.taken_cancel;

   // Highest-priority redirect pulse of this cycle.
   always_comb begin
      pulse_lvl    = redir_pulse_lvl(wb_ex, ertn_flush, br_bus.taken);
      pulse_target = 32'h0;
      if (wb_ex) begin
         pulse_target = ex_entry;
      end else if (ertn_flush) begin
         pulse_target = era;
      end else if (br_bus.taken) begin
         pulse_target = br_bus.target;
      end
   end

   pre_if_redirect_buf u_redirect_buf (
      .clk          (clk),
      .reset        (reset),
      .pulse_lvl    (pulse_lvl),
      .pulse_target (pulse_target),
      .handoff      (valid_c),
      .pulse_win_c  (pulse_win_c),
      .held_valid   (held_valid),
      .held_target  (held_target)
   );

   always_comb begin
      nextpc_c = if_pc + 32'd4;
      if (pulse_win_c) begin
         nextpc_c = pulse_target;
      end else if (held_valid) begin
         nextpc_c = held_target;
      end
   end

   assign adef_c       = (nextpc_c[1:0] != 2'b00);
   assign req_c        = started_q & IF_allowin & ~adef_c & ~ex_stall_q
                         & (io_cnt_q < IO_CNT_W'(MAX_OUTSTANDING));
   assign handshake_c  = req_c & inst_sram_addr_ok;
   assign adef_issue_c = started_q & adef_c & IF_allowin & ~ex_stall_q;
   assign valid_c      = handshake_c | adef_issue_c;

   always_comb begin
      started_d  = 1'b1;
      ex_stall_d = ex_stall_q;
      io_cnt_d   = io_cnt_q;
      preif_pc_d = preif_pc_q;

      // Only a flush can restart fetch after an ADEF was handed off.
      if (wb_ex || ertn_flush) begin
         ex_stall_d = 1'b0;
      end else if (adef_issue_c) begin
         ex_stall_d = 1'b1;
      end

      case ({handshake_c, inst_sram_data_ok})
         2'b10:   io_cnt_d = io_cnt_q + IO_CNT_W'(1);
         2'b01:   io_cnt_d = (io_cnt_q == '0) ? io_cnt_q : io_cnt_q - IO_CNT_W'(1);
         default: io_cnt_d = io_cnt_q;
      endcase

      if (valid_c) begin
         preif_pc_d = nextpc_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         started_q  <= 1'b0;
         ex_stall_q <= 1'b0;
         io_cnt_q   <= '0;
         preif_pc_q <= RESET_PC - 32'd4;
      end else begin
         started_q  <= started_d;
         ex_stall_q <= ex_stall_d;
         io_cnt_q   <= io_cnt_d;
         preif_pc_q <= preif_pc_d;
      end
   end

   always_comb begin
      bus_c.pc       = preif_pc_q;
      bus_c.nextpc   = nextpc_c;
      bus_c.ex       = adef_c;
      bus_c.ex_code  = adef_c ? adef_ex_code() : 15'h0;
      bus_c.ex_vaddr = adef_c ? nextpc_c : 32'h0;
   end

   assign inst_sram_req     = req_c;
   assign inst_sram_wr      = 1'b0;
   assign inst_sram_size    = 2'b10;
   assign inst_sram_wstrb   = 4'h0;
   assign inst_sram_wdata   = 32'h0;
   assign inst_sram_addr    = nextpc_c;
   assign preIF_to_IF_valid = valid_c;
   assign preIF_to_IF_BUS   = bus_c;
   assign IO_cnt            = io_cnt_q;

   // A response with nothing outstanding is a slave protocol violation.
   a_io_underflow: assert property (@(posedge clk) disable iff (reset)
      !(inst_sram_data_ok && (io_cnt_q == '0)));

endmodule
